// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 16-bit bus datapath.
// Steps one-hot ticks T0..T3 and decodes IR into bus/enable strobes.
module control_sequencer #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      instr,
  input  logic             z_flag,
  output logic             ir_load,
  output logic [NREGS-1:0] r_out,
  output logic [NREGS-1:0] r_in,
  output logic             imm_out,
  output logic             din_out,
  output logic             a_in,
  output logic             g_in,
  output logic             g_out,
  output logic             alu_sub,
  output logic             addr_in,
  output logic             dout_in,
  output logic             w_en,
  output logic             done,
  output logic             halted,
  output logic [3:0]       tick
);

  typedef enum logic [3:0] {
    S_HALT = 4'b0000,
    S_T0   = 4'b0001,
    S_T1   = 4'b0010,
    S_T2   = 4'b0100,
    S_T3   = 4'b1000
  } state_e;

  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB,
    OP_LD, OP_ST, OP_MVNZ, OP_HALT
  } op_e;

  state_e state_q, state_d;
  logic [15:0] ir_q, ir_d;

  op_e op;
  logic [3:0] rx, ry;
  logic [NREGS-1:0] rx_oh, ry_oh;
  logic unused_imm;

  assign op = op_e'(ir_q[15:13]);
  assign rx = ir_q[12:9];
  assign ry = ir_q[8:5];
  // immediate goes to the datapath sign-extender, not used here
  assign unused_imm = ^ir_q[4:0];

  // Out-of-range indices simply match no bit
  always_comb begin
    rx_oh = '0;
    ry_oh = '0;
    for (int i = 0; i < NREGS; i++) begin
      rx_oh[i] = (32'(rx) == i);
      ry_oh[i] = (32'(ry) == i);
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_T0: begin
        if (run) begin
          state_d = S_T1;
          ir_d    = instr;
        end
      end
      S_T1: begin
        case (op)
          OP_ADD, OP_SUB,
          OP_LD, OP_ST: state_d = S_T2;
          OP_HALT:      state_d = S_HALT;
          default:      state_d = S_T0;
        endcase
      end
      S_T2: state_d = (op == OP_ST) ? S_T0 : S_T3;
      S_T3: state_d = S_T0;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign tick = state_q;

  always_comb begin
    ir_load = 1'b0;
    r_out   = '0;
    r_in    = '0;
    imm_out = 1'b0;
    din_out = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    alu_sub = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_en    = 1'b0;
    done    = 1'b0;
    halted  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_T0: ir_load = run;
        S_T1: begin
          case (op)
            OP_MV: begin
              r_out = ry_oh;
              r_in  = rx_oh;
              done  = 1'b1;
            end
            OP_MVI: begin
              imm_out = 1'b1;
              r_in    = rx_oh;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              r_out = rx_oh;
              a_in  = 1'b1;
            end
            OP_LD, OP_ST: begin
              r_out   = ry_oh;
              addr_in = 1'b1;
            end
            OP_MVNZ: begin
              done = 1'b1;
              if (!z_flag) begin
                r_out = ry_oh;
                r_in  = rx_oh;
              end
            end
            default: done = 1'b1;
          endcase
        end
        S_T2: begin
          case (op)
            OP_ADD, OP_SUB: begin
              r_out   = ry_oh;
              g_in    = 1'b1;
              alu_sub = (op == OP_SUB);
            end
            OP_ST: begin
              r_out   = rx_oh;
              dout_in = 1'b1;
              w_en    = 1'b1;
              done    = 1'b1;
            end
            default: ;
          endcase
        end
        S_T3: begin
          case (op)
            OP_ADD, OP_SUB: begin
              g_out = 1'b1;
              r_in  = rx_oh;
              done  = 1'b1;
            end
            OP_LD: begin
              din_out = 1'b1;
              r_in    = rx_oh;
              done    = 1'b1;
            end
            default: ;
          endcase
        end
        default: halted = 1'b1;
      endcase
    end
  end

endmodule
